// File: rtl/gmii_tx_pkg.sv
// rtl/gmii_tx_pkg.sv - shared constants and state encoding for the GMII transmit scheduler
package gmii_tx_pkg;

    localparam logic PKT_VIDEO = 1'b0;
    localparam logic PKT_AUDIO = 1'b1;

    localparam int AUD_BLK_WORDS_DEF = 32;
    localparam int IFG_CYCLES_DEF    = 12;

    localparam int LEN_W     = 11;
    localparam int SEQ_W     = 16;
    localparam int AUD_CNT_W = 4;
    localparam int ADE_NUM_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        GAP   = 2'd3
    } sched_state_t;

endpackage

// File: rtl/gmii_tx_audreq.sv
// rtl/gmii_tx_audreq.sv - audio send-window edge capture and ADE block accumulation
module gmii_tx_audreq
    import gmii_tx_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 adesig,
    input  logic [ADE_NUM_W-1:0] ade_num,
    input  logic                 grant,
    output logic [AUD_CNT_W-1:0] aud_cnt,
    output logic                 aud_pend,
    output logic                 aud_ovf
);

    logic                 adesig_q;
    logic                 ade_edge;
    logic [AUD_CNT_W-1:0] base;
    logic [AUD_CNT_W:0]   sum;

    assign ade_edge = adesig & ~adesig_q;
    // A grant in the same cycle empties the accumulator before the new blocks land.
    assign base     = grant ? '0 : aud_cnt;
    assign sum      = {1'b0, base} + {1'b0, ade_num};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adesig_q <= 1'b0;
            aud_cnt  <= '0;
            aud_pend <= 1'b0;
            aud_ovf  <= 1'b0;
        end else begin
            adesig_q <= adesig;
            if (ade_edge && (ade_num != '0)) begin
                aud_cnt  <= sum[AUD_CNT_W] ? '1 : sum[AUD_CNT_W-1:0];
                aud_pend <= 1'b1;
                if (sum[AUD_CNT_W]) begin
                    aud_ovf <= 1'b1;
                end
            end else if (grant) begin
                aud_cnt  <= '0;
                aud_pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/gmii_tx_sched.sv
// rtl/gmii_tx_sched.sv - video/audio frame scheduler in front of the GMII transmit engine
module gmii_tx_sched
    import gmii_tx_pkg::*;
#(
    parameter int VID_PKT_WORDS  = 300,
    parameter int LVL_W          = 11,
    parameter int VID_HI_WM      = 1536,
    parameter int AUD_BLK_WORDS  = AUD_BLK_WORDS_DEF,
    parameter int AUD_MAX_CONSEC = 2,
    parameter int IFG_CYCLES     = IFG_CYCLES_DEF,
    parameter int TIMEOUT        = 4095
) (
    input  logic                 tx_clk,
    input  logic                 sys_rst_n,
    input  logic                 sw,
    input  logic [LVL_W-1:0]     vid_level,
    input  logic                 vempty,
    input  logic                 adesig,
    input  logic [ADE_NUM_W-1:0] ade_num,
    input  logic                 aempty,
    output logic                 pkt_start,
    output logic                 pkt_type,
    output logic [LEN_W-1:0]     pkt_len,
    output logic [SEQ_W-1:0]     pkt_seq,
    input  logic                 pkt_done,
    output logic                 busy,
    output logic                 err_timeout,
    output logic                 aud_ovf
);

    localparam int WAIT_W   = $clog2(TIMEOUT + 1);
    localparam int GAP_W    = $clog2(IFG_CYCLES + 1);
    localparam int CONSEC_W = 4;

    sched_state_t         state;
    sched_state_t         state_nxt;
    logic [AUD_CNT_W-1:0] aud_cnt;
    logic                 aud_pend;
    logic                 vreq;
    logic                 vurg;
    logic                 areq;
    logic                 grant_vid;
    logic                 grant_aud;
    logic                 timeout_hit;
    logic [SEQ_W-1:0]     vid_seq;
    logic [SEQ_W-1:0]     aud_seq;
    logic [CONSEC_W-1:0]  aud_consec;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [GAP_W-1:0]     gap_cnt;

    gmii_tx_audreq u_audreq (
        .clk      (tx_clk),
        .rst_n    (sys_rst_n),
        .adesig   (adesig),
        .ade_num  (ade_num),
        .grant    (grant_aud),
        .aud_cnt  (aud_cnt),
        .aud_pend (aud_pend),
        .aud_ovf  (aud_ovf)
    );

    assign vreq = (vid_level >= LVL_W'(VID_PKT_WORDS)) && !vempty;
    assign vurg = vid_level >= LVL_W'(VID_HI_WM);
    assign areq = aud_pend && !aempty;

    always_ff @(posedge tx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        grant_vid   = 1'b0;
        grant_aud   = 1'b0;
        timeout_hit = 1'b0;
        pkt_start   = 1'b0;
        busy        = 1'b0;
        case (state)
            IDLE: begin
                // Audio may win over plain video only a bounded number of times in a row.
                if (sw) begin
                    if (vurg) begin
                        grant_vid = 1'b1;
                    end else if (areq && ((aud_consec < CONSEC_W'(AUD_MAX_CONSEC)) || !vreq)) begin
                        grant_aud = 1'b1;
                    end else if (vreq) begin
                        grant_vid = 1'b1;
                    end
                end
                if (grant_vid || grant_aud) begin
                    state_nxt = START;
                end
            end
            START: begin
                pkt_start = 1'b1;
                busy      = 1'b1;
                state_nxt = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (pkt_done) begin
                    state_nxt = GAP;
                end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = GAP;
                end
            end
            GAP: begin
                busy = 1'b1;
                if (gap_cnt == GAP_W'(IFG_CYCLES - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge tx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pkt_type    <= PKT_VIDEO;
            pkt_len     <= '0;
            pkt_seq     <= '0;
            vid_seq     <= '0;
            aud_seq     <= '0;
            aud_consec  <= '0;
            wait_cnt    <= '0;
            gap_cnt     <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (grant_vid) begin
                pkt_type   <= PKT_VIDEO;
                pkt_len    <= LEN_W'(VID_PKT_WORDS);
                pkt_seq    <= vid_seq;
                vid_seq    <= vid_seq + 1'b1;
                aud_consec <= '0;
            end else if (grant_aud) begin
                pkt_type <= PKT_AUDIO;
                pkt_len  <= LEN_W'(aud_cnt) * LEN_W'(AUD_BLK_WORDS);
                pkt_seq  <= aud_seq;
                aud_seq  <= aud_seq + 1'b1;
                if (aud_consec != '1) begin
                    aud_consec <= aud_consec + 1'b1;
                end
            end
            wait_cnt <= (state == BUSY) ? wait_cnt + 1'b1 : '0;
            gap_cnt  <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gmii_tx_sched.sv
// tb/tb_gmii_tx_sched.sv - randomized and directed bench for gmii_tx_sched against a frame-level model
`timescale 1ns/1ps
module tb_gmii_tx_sched;

    localparam int TIMEOUT = 4095;
    localparam int IFG     = 12;
    localparam int VPW     = 300;
    localparam int HIWM    = 1536;
    localparam int ABW     = 32;
    localparam int MAXC    = 2;

    logic        tx_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        sw = 1'b0;
    logic [10:0] vid_level = '0;
    logic        vempty = 1'b1;
    logic        adesig = 1'b0;
    logic [3:0]  ade_num = '0;
    logic        aempty = 1'b1;
    logic        pkt_done = 1'b0;
    logic        pkt_start;
    logic        pkt_type;
    logic [10:0] pkt_len;
    logic [15:0] pkt_seq;
    logic        busy;
    logic        err_timeout;
    logic        aud_ovf;

    gmii_tx_sched dut (
        .tx_clk      (tx_clk),
        .sys_rst_n   (sys_rst_n),
        .sw          (sw),
        .vid_level   (vid_level),
        .vempty      (vempty),
        .adesig      (adesig),
        .ade_num     (ade_num),
        .aempty      (aempty),
        .pkt_start   (pkt_start),
        .pkt_type    (pkt_type),
        .pkt_len     (pkt_len),
        .pkt_seq     (pkt_seq),
        .pkt_done    (pkt_done),
        .busy        (busy),
        .err_timeout (err_timeout),
        .aud_ovf     (aud_ovf)
    );

    always #4 tx_clk = ~tx_clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Frame-level reference: edge indices of grant/done/free, plus audio bookkeeping.
    int e = 0;
    int m_free_at, m_grant_edge, m_done_edge;
    bit m_nodone, m_ade_prev, m_pend, m_ovf, m_err, m_type, exp_start;
    int m_cnt, m_consec, m_vseq, m_aseq, m_len, m_seq;
    int eng_mode = 0;
    int fixed_lat = 1;
    bit spur_en = 0;
    int st_type[$], st_len[$], st_seq[$], st_edge[$];
    int lv_tab[8] = '{0, 100, 299, 300, 400, 1535, 1536, 2000};

    task automatic model_init();
        m_free_at = e; m_grant_edge = e - 100; m_done_edge = e - 100;
        m_nodone = 0; m_ade_prev = 0; m_pend = 0; m_ovf = 0; m_err = 0;
        m_type = 0; exp_start = 0; m_cnt = 0; m_consec = 0;
        m_vseq = 0; m_aseq = 0; m_len = 0; m_seq = 0;
    endtask

    task automatic clear_q();
        st_type.delete(); st_len.delete(); st_seq.delete(); st_edge.delete();
    endtask

    task automatic model_edge();
        bit edge_a, vreq, vurg, areq, gv, ga;
        int lat, sum, base;
        edge_a = adesig && !m_ade_prev;
        m_ade_prev = adesig;
        gv = 0; ga = 0; exp_start = 0;
        if (e >= m_free_at && sw) begin
            vreq = (vid_level >= VPW) && !vempty;
            vurg = vid_level >= HIWM;
            areq = m_pend && !aempty;
            if (vurg) gv = 1;
            else if (areq && (m_consec < MAXC || !vreq)) ga = 1;
            else if (vreq) gv = 1;
        end
        if (gv || ga) begin
            lat = (eng_mode == 0) ? int'($urandom_range(1, 40)) : ((eng_mode == 1) ? fixed_lat : TIMEOUT);
            m_nodone = (eng_mode == 2);
            m_grant_edge = e;
            m_done_edge = e + 1 + lat;
            m_free_at = m_done_edge + IFG + 1;
            exp_start = 1;
            if (gv) begin
                m_type = 0; m_len = VPW; m_seq = m_vseq;
                m_vseq = (m_vseq + 1) % 65536; m_consec = 0;
            end else begin
                m_type = 1; m_len = m_cnt * ABW; m_seq = m_aseq;
                m_aseq = (m_aseq + 1) % 65536;
                if (m_consec < 15) m_consec++;
            end
        end
        if (m_nodone && e == m_done_edge) m_err = 1;
        base = ga ? 0 : m_cnt;
        if (edge_a && ade_num != 0) begin
            sum = base + int'(ade_num);
            m_cnt = (sum > 15) ? 15 : sum;
            m_pend = 1;
            if (sum > 15) m_ovf = 1;
        end else if (ga) begin
            m_cnt = 0; m_pend = 0;
        end
    endtask

    task automatic cycle();
        bit spur;
        spur = spur_en && ($urandom_range(0, 15) == 0) && !(e >= m_grant_edge + 2 && e <= m_done_edge);
        pkt_done = ((e == m_done_edge) && !m_nodone) || spur;
        model_edge();
        @(posedge tx_clk);
        @(negedge tx_clk);
        check("pkt_start", pkt_start, exp_start);
        check("busy", busy, (e >= m_grant_edge && e <= m_free_at - 2));
        check("err_timeout", err_timeout, m_err);
        check("aud_ovf", aud_ovf, m_ovf);
        check("pkt_type", pkt_type, m_type);
        check("pkt_len", pkt_len, m_len);
        check("pkt_seq", pkt_seq, m_seq);
        if (pkt_start === 1'b1) begin
            st_type.push_back(int'(pkt_type)); st_len.push_back(int'(pkt_len));
            st_seq.push_back(int'(pkt_seq)); st_edge.push_back(e);
        end
        e++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pulse(input int n);
        adesig = 1'b1; ade_num = 4'(n);
        cycle();
        adesig = 1'b0; ade_num = '0;
        cycle();
    endtask

    task automatic wait_starts(input int n, input int budget, input string tag);
        int k = 0;
        while (st_type.size() < n && k < budget) begin
            cycle();
            k++;
        end
        if (st_type.size() < n) check(tag, st_type.size(), n);
    endtask

    initial begin
        int k, seen;
        model_init();
        repeat (3) @(negedge tx_clk);
        check("rst_start", pkt_start, 0);
        check("rst_busy", busy, 0);
        check("rst_type", pkt_type, 0);
        check("rst_len", pkt_len, 0);
        check("rst_seq", pkt_seq, 0);
        check("rst_err", err_timeout, 0);
        check("rst_ovf", aud_ovf, 0);
        sys_rst_n = 1'b1;

        // audio only
        sw = 1; vid_level = 0; vempty = 1; aempty = 0; eng_mode = 1; fixed_lat = 96;
        run(3);
        pulse(3);
        wait_starts(1, 20, "aud_wait");
        run(200);
        check("aud_count", st_type.size(), 1);
        if (st_type.size() >= 1) begin
            check("aud_type", st_type[0], 1);
            check("aud_len", st_len[0], 96);
            check("aud_seq", st_seq[0], 0);
        end

        // video only, 300-cycle engine
        clear_q();
        vid_level = 400; vempty = 0; aempty = 1; fixed_lat = 300;
        wait_starts(3, 1500, "vid_wait");
        if (st_type.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                check("vid_type", st_type[i], 0);
                check("vid_seq", st_seq[i], i);
            end
            check("vid_gap1", st_edge[1] - st_edge[0], 314);
            check("vid_gap2", st_edge[2] - st_edge[1], 314);
        end

        // contention: expect A, A, V, A
        clear_q();
        aempty = 0; fixed_lat = 20;
        pulse(1);
        seen = 0; k = 0;
        while (st_type.size() < 4 && k < 2000) begin
            cycle();
            k++;
            if (st_type.size() > seen) begin
                seen = st_type.size();
                if (seen < 4) pulse(1);
            end
        end
        check("cont_count", st_type.size(), 4);
        if (st_type.size() >= 4) begin
            check("cont_0", st_type[0], 1);
            check("cont_1", st_type[1], 1);
            check("cont_2", st_type[2], 0);
            check("cont_3", st_type[3], 1);
            check("cont_len3", st_len[3], 64);
        end

        // urgent video beats pending audio
        clear_q();
        vid_level = 1600;
        pulse(2);
        k = 0;
        while (st_type.size() < 2 && k < 1000) begin
            cycle();
            k++;
            if (st_type.size() == 1) vid_level = 0;
        end
        check("urg_count", st_type.size(), 2);
        if (st_type.size() >= 2) begin
            check("urg_0", st_type[0], 0);
            check("urg_1", st_type[1], 1);
            check("urg_len1", st_len[1], 64);
        end

        // overflow: 9 + 9 saturates at 15 blocks
        sw = 0; vid_level = 0;
        run(60);
        check("ovf_pre", aud_ovf, 0);
        pulse(9);
        pulse(9);
        check("ovf_set", aud_ovf, 1);
        clear_q();
        sw = 1;
        wait_starts(1, 50, "ovf_wait");
        if (st_type.size() >= 1) begin
            check("ovf_type", st_type[0], 1);
            check("ovf_len", st_len[0], 480);
        end

        // timeout: engine never answers
        clear_q();
        eng_mode = 2; vid_level = 400; vempty = 0; aempty = 1;
        wait_starts(1, 600, "to_wait");
        sw = 0;
        k = 0;
        while (err_timeout !== 1'b1 && k < 5000) begin
            cycle();
            k++;
        end
        if (st_edge.size() >= 1) check("to_lat", (e - 1) - st_edge[0], 4096);
        run(30);
        check("to_idle", busy, 0);
        eng_mode = 0;

        // randomized traffic
        spur_en = 1;
        for (int i = 0; i < 3000; i++) begin
            sw = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) vid_level = 11'(lv_tab[$urandom_range(0, 7)]);
            if ($urandom_range(0, 7) == 0) vempty = ~vempty;
            if ($urandom_range(0, 5) == 0) adesig = ~adesig;
            ade_num = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 6));
            aempty = ($urandom_range(0, 4) == 0);
            cycle();
        end

        // reset in the middle of a frame
        spur_en = 0; eng_mode = 2; sw = 1; vid_level = 400; vempty = 0; adesig = 0; ade_num = 0;
        clear_q();
        wait_starts(1, 300, "rst_wait");
        run(5);
        sys_rst_n = 1'b0;
        #1;
        check("mid_start", pkt_start, 0);
        check("mid_busy", busy, 0);
        check("mid_type", pkt_type, 0);
        check("mid_len", pkt_len, 0);
        check("mid_seq", pkt_seq, 0);
        check("mid_err", err_timeout, 0);
        check("mid_ovf", aud_ovf, 0);
        @(negedge tx_clk);
        model_init();
        sys_rst_n = 1'b1;
        eng_mode = 0;
        clear_q();
        wait_starts(1, 100, "post_wait");
        if (st_type.size() >= 1) check("post_seq", st_seq[0], 0);
        run(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gmii_tx_sched.md
Name: gmii_tx_sched

Overview:
- Packet scheduler in front of the GMII transmit engine, in the tx_clk (125 MHz) domain.
- Decides whether the next Ethernet frame carries a video chunk (48-bit words from the video FIFO) or an audio/aux burst (24-bit words from the aux FIFO), and when it starts.
- Issues one start command per frame, holds off until the engine reports done, then enforces the inter-frame gap.
- Arbitrates fairly between the two sources, with urgent-video override and audio starvation bounding.

Parameters:
- VID_PKT_WORDS, 300, video words per video frame (1200 active pixels per line / 4 frames).
- LVL_W, 11, width of video FIFO level input.
- VID_HI_WM, 1536, video level at or above which video becomes urgent.
- AUD_BLK_WORDS, 32, aux words per ADE block.
- AUD_MAX_CONSEC, 2, max consecutive audio grants while video is requesting.
- IFG_CYCLES, 12, idle cycles between frames (12 byte times).
- TIMEOUT, 4095, max cycles waiting for pkt_done.

Ports:
- tx_clk  in  1  GMII transmit clock; all logic on rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- sw  in  1  scheduler enable; 0 = no new grants.
- vid_level  in  LVL_W  video FIFO read-side word count.
- vempty  in  1  video FIFO empty.
- adesig  in  1  audio send window from the timing logic; level signal.
- ade_num  in  4  number of ADE blocks captured in the last line.
- aempty  in  1  aux FIFO empty.
- pkt_start  out  1  one-cycle frame start command.
- pkt_type  out  1  0 = video, 1 = audio; valid with pkt_start and held until done.
- pkt_len  out  11  words in the frame; held like pkt_type.
- pkt_seq  out  16  per-type sequence number; held like pkt_type.
- pkt_done  in  1  one-cycle pulse from the engine at end of frame.
- busy  out  1  high from the grant through the end of the gap.
- err_timeout  out  1  sticky; frame aborted on timeout.
- aud_ovf  out  1  sticky; audio request accumulation saturated.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, seq counters 0, aud_pend 0, aud_cnt 0, aud_consec 0.
- Audio request capture (any state):
  - Rising edge of adesig is detected with a registered copy of adesig.
  - On an edge with ade_num != 0: aud_cnt <= min(aud_cnt + ade_num, 15); aud_pend <= 1.
  - If the sum exceeds 15, aud_ovf <= 1.
  - An edge with ade_num == 0 is ignored.
  - An edge in the same cycle as an audio grant adds to the post-grant value, which is 0.
- Request terms:
  - vreq = vid_level >= VID_PKT_WORDS and !vempty.
  - vurg = vid_level >= VID_HI_WM.
  - areq = aud_pend and !aempty.
- Arbitration in IDLE when sw = 1, priority order:
  1. vurg: video.
  2. areq and (aud_consec < AUD_MAX_CONSEC or !vreq): audio.
  3. vreq: video.
  4. Otherwise stay in IDLE.
- On a video grant:
  - pkt_type = 0, pkt_len = VID_PKT_WORDS, pkt_seq = vid_seq.
  - Then vid_seq += 1 (wraps at 16 bits); aud_consec <= 0.
- On an audio grant:
  - pkt_type = 1, pkt_len = aud_cnt * AUD_BLK_WORDS (max 480), pkt_seq = aud_seq.
  - Then aud_seq += 1; aud_cnt <= 0; aud_pend <= 0; aud_consec += 1 (saturating).
- State machine:
  - IDLE -> START on a grant; registered, so pkt_start is high the cycle after the decision cycle.
  - START (1 cycle, pkt_start = 1) -> BUSY.
  - BUSY: wait for pkt_done, then -> GAP. If the wait counter reaches TIMEOUT: err_timeout <= 1, -> GAP.
  - GAP: count IFG_CYCLES cycles, then -> IDLE.
- busy = 1 in START, BUSY and GAP.
- A pkt_done outside BUSY is ignored.
- Minimum frame-to-frame spacing is 1 + frame length + IFG_CYCLES + 1.
- sw deasserting mid-frame has no effect on the current frame; it only blocks the next grant in IDLE.
- Reset mid-frame aborts immediately; all outputs return to 0.

Decomposition:
- Shared package gmii_tx_pkg holds:
  - PKT_VIDEO/PKT_AUDIO constants.
  - State encoding (IDLE, START, BUSY, GAP).
  - AUD_BLK_WORDS and IFG_CYCLES defaults.
- One natural sub-module: gmii_tx_audreq (adesig edge detect, aud_cnt accumulation/saturation, aud_ovf).
- Arbitration and FSM stay in the top.

Test Plan:
- Video only: vid_level = 400, vempty = 0, engine returns pkt_done 300 cycles after start -> pkt_start with type 0, len 300, seq 0,1,2…; successive starts exactly 314 cycles apart.
- Audio only: adesig edge with ade_num = 3, aempty = 0 -> one start, type 1, len 96, aud_seq 0; aud_pend clears; no further grants.
- Contention: vreq held, three audio edges (ade_num = 1) spaced so each is pending at arbitration -> grant order A, A, V, A (aud_consec limit 2).
- Urgent: vid_level = 1600 with audio pending -> video granted first; audio next.
- Overflow: edges with ade_num = 9 then 9 before any grant -> aud_cnt = 15, aud_ovf = 1, len 480.
- Timeout/reset: withhold pkt_done -> err_timeout = 1 after 4095 cycles, GAP then IDLE. Separately, assert sys_rst_n low mid-BUSY -> outputs 0 the same cycle.
